reuse_ctrl: RTL

//   Frame sequencer for reuse_module (the 2-line register-array buffer feeding a 3x3 conv window).

---
 rtl/reuse_ctrl_if.sv | 30 +++
 rtl/reuse_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reuse_ctrl_if.sv
// Pixel stream bundle between the upstream source, reuse_ctrl and reuse_module.
// The master side feeds pixels; the slave side (reuse_ctrl) drives the buffer-facing outputs.
interface reuse_ctrl_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_ready;
    logic                 reuse_en;
    logic [BIT_WIDTH-1:0] pix_out;
    logic                 win_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  reuse_en,
        input  pix_out,
        input  win_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output reuse_en,
        output pix_out,
        output win_valid
    );
endinterface

// File: rtl/reuse_ctrl.sv
// Frame sequencer for reuse_module: accepts a raster pixel stream, re-registers each pixel
// with a shift enable, tracks column/row position and flags beats that complete a KxK window.
module reuse_ctrl #(
    parameter int BIT_WIDTH = 8,
    parameter int CNT_W     = 9,
    parameter int KSIZE     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    reuse_ctrl_if.slave      bus,
    input  logic             start_i,
    input  logic [CNT_W-1:0] col_i,
    input  logic [CNT_W-1:0] row_i,
    output logic [CNT_W-1:0] col_cnt_o,
    output logic [CNT_W-1:0] row_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o
);

    localparam logic [CNT_W-1:0] K_CNT  = CNT_W'(KSIZE);
    localparam logic [CNT_W-1:0] K_M1   = CNT_W'(KSIZE - 1);
    localparam logic [CNT_W-1:0] K_M2   = CNT_W'(KSIZE - 2);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_0  = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [CNT_W-1:0]     col_cfg_q, col_cfg_d;
    logic [CNT_W-1:0]     row_cfg_q, row_cfg_d;
    logic [CNT_W-1:0]     col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]     row_cnt_q, row_cnt_d;
    logic [BIT_WIDTH-1:0] pix_q,     pix_d;
    logic                 en_q,      en_d;
    logic                 win_q,     win_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 cfg_ok_s;
    logic                 last_col_s;
    logic                 last_row_s;

    assign in_ready_s = (state_q == S_FILL) || (state_q == S_RUN);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign cfg_ok_s   = (col_i >= K_CNT) && (row_i >= K_CNT);
    assign last_col_s = (col_cnt_q == (col_cfg_q - CNT_1));
    assign last_row_s = (row_cnt_q == (row_cfg_q - CNT_1));

    // Next-state, config latch and raster position counters.
    always_comb begin
        state_d   = state_q;
        col_cfg_d = col_cfg_q;
        row_cfg_d = row_cfg_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        cfg_err_d = 1'b0;

        if (accept_s) begin
            if (last_col_s) begin
                col_cnt_d = CNT_0;
                row_cnt_d = row_cnt_q + CNT_1;
            end else begin
                col_cnt_d = col_cnt_q + CNT_1;
                row_cnt_d = row_cnt_q;
            end
        end else begin
            col_cnt_d = col_cnt_q;
            row_cnt_d = row_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_ok_s) begin
                        state_d   = S_FILL;
                        col_cfg_d = col_i;
                        row_cfg_d = row_i;
                        col_cnt_d = CNT_0;
                        row_cnt_d = CNT_0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            // FILL ends once the last buffered row before the first window row is complete.
            S_FILL: begin
                if (accept_s && last_col_s && (row_cnt_q == K_M2)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_RUN: begin
                if (accept_s && last_col_s && last_row_s) begin
                    state_d   = S_DONE;
                    col_cnt_d = CNT_0;
                    row_cnt_d = CNT_0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                col_cnt_d = CNT_0;
                row_cnt_d = CNT_0;
            end
        endcase
    end

    // Pixel re-register, shift enable and window flag for the accepted beat.
    always_comb begin
        en_d  = accept_s;
        win_d = accept_s && (row_cnt_q >= K_M1) && (col_cnt_q >= K_M1);
        if (accept_s) begin
            pix_d = bus.in_data;
        end else begin
            pix_d = pix_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_cfg_q <= CNT_0;
            row_cfg_q <= CNT_0;
            col_cnt_q <= CNT_0;
            row_cnt_q <= CNT_0;
            pix_q     <= {BIT_WIDTH{1'b0}};
            en_q      <= 1'b0;
            win_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cfg_q <= col_cfg_d;
            row_cfg_q <= row_cfg_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            pix_q     <= pix_d;
            en_q      <= en_d;
            win_q     <= win_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.reuse_en  = en_q;
    assign bus.pix_out   = pix_q;
    assign bus.win_valid = win_q;
    assign col_cnt_o     = col_cnt_q;
    assign row_cnt_o     = row_cnt_q;
    assign busy_o        = in_ready_s;
    assign done_o        = (state_q == S_DONE);
    assign cfg_err_o     = cfg_err_q;

endmodule
